// File: rtl/mult_fu_if.sv
// Issue (reservation station -> FU) and CDB write-back (FU -> arbiter) signal bundle.
// master = issuer/arbiter side, slave = the multiply unit.
interface mult_fu_if #(
   parameter int ROB_ID_W = 8,
   parameter int PREG_W   = 6
);
   logic                flush;
   logic                start_calculate;
   logic [1:0]          mul_op;
   logic [31:0]         rs1_v;
   logic [31:0]         rs2_v;
   logic [ROB_ID_W-1:0] issue_rob_id;
   logic [PREG_W-1:0]   issue_pd;
   logic                mult_status;
   logic                cdb_grant;
   logic                write_from_fu;
   logic [ROB_ID_W-1:0] cdb_rob_id;
   logic [PREG_W-1:0]   cdb_pd;
   logic [31:0]         cdb_value;

   modport master (
      output flush, start_calculate, mul_op, rs1_v, rs2_v, issue_rob_id, issue_pd, cdb_grant,
      input  mult_status, write_from_fu, cdb_rob_id, cdb_pd, cdb_value
   );

   modport slave (
      input  flush, start_calculate, mul_op, rs1_v, rs2_v, issue_rob_id, issue_pd, cdb_grant,
      output mult_status, write_from_fu, cdb_rob_id, cdb_pd, cdb_value
   );
endinterface

// File: rtl/mult_fu.sv
// Iterative 32-step shift-add RV32M multiplier; result visible 34 cycles after accept.
// Result is held on the CDB interface until granted (unbounded back-pressure); flush/rst squash it.
module mult_fu #(
   parameter int ROB_ID_W = 8,
   parameter int PREG_W   = 6
) (
   input  logic     clk,
   input  logic     rst,
   mult_fu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   state_t              state, next_state;
   logic [4:0]          cnt;
   logic [1:0]          op_q;
   logic [31:0]         a_mag, b_mag;
   logic                neg_q;
   logic [63:0]         acc;
   logic [63:0]         product;
   logic [63:0]         partial;
   logic [ROB_ID_W-1:0] rob_q;
   logic [PREG_W-1:0]   pd_q;

   logic                status;
   logic                accept;
   logic                rs1_neg, rs2_neg;

   logic                write_q;
   logic [ROB_ID_W-1:0] cdb_rob_q;
   logic [PREG_W-1:0]   cdb_pd_q;
   logic [31:0]         cdb_value_q;

   // Only the operands that the opcode treats as signed contribute a sign.
   assign rs1_neg = ((bus.mul_op == OP_MULH) || (bus.mul_op == OP_MULHSU)) && bus.rs1_v[31];
   assign rs2_neg = (bus.mul_op == OP_MULH) && bus.rs2_v[31];

   assign accept  = bus.start_calculate && status;
   assign partial = {32'd0, a_mag} << cnt;
   assign product = neg_q ? (~acc + 64'd1) : acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      status     = 1'b0;
      case (state)
         IDLE: status = 1'b1;
         DONE: status = bus.cdb_grant;
         default: status = 1'b0;
      endcase
      if (rst || bus.flush) begin
         status = 1'b0;
      end

      case (state)
         IDLE: if (accept) next_state = BUSY;
         BUSY: if (cnt == 5'd31) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: begin
            if (accept) begin
               next_state = BUSY;
            end else if (bus.cdb_grant) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (bus.flush) begin
         next_state = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         write_q     <= 1'b0;
         cdb_rob_q   <= '0;
         cdb_pd_q    <= '0;
         cdb_value_q <= '0;
         cnt         <= '0;
      end else begin
         if (state == DONE && bus.cdb_grant) begin
            write_q <= 1'b0;
         end

         if (accept) begin
            op_q  <= bus.mul_op;
            rob_q <= bus.issue_rob_id;
            pd_q  <= bus.issue_pd;
            a_mag <= rs1_neg ? (~bus.rs1_v + 32'd1) : bus.rs1_v;
            b_mag <= rs2_neg ? (~bus.rs2_v + 32'd1) : bus.rs2_v;
            neg_q <= rs1_neg ^ rs2_neg;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == BUSY) begin
            if (b_mag[cnt]) begin
               acc <= acc + partial;
            end
            cnt <= cnt + 5'd1;
         end else if (state == FIX) begin
            write_q     <= 1'b1;
            cdb_rob_q   <= rob_q;
            cdb_pd_q    <= pd_q;
            cdb_value_q <= (op_q == OP_MUL) ? product[31:0] : product[63:32];
         end
      end
   end

   assign bus.mult_status   = status;
   assign bus.write_from_fu = write_q;
   assign bus.cdb_rob_id    = cdb_rob_q;
   assign bus.cdb_pd        = cdb_pd_q;
   assign bus.cdb_value     = cdb_value_q;
endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: vector table with grant held high, then back-pressure,
// back-to-back, flush and reset corner sequences.
module tb_mult_fu;
   localparam int ROB_ID_W = 8;
   localparam int PREG_W   = 6;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  rob;
      logic [5:0]  pd;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mult_fu_if #(.ROB_ID_W(ROB_ID_W), .PREG_W(PREG_W)) bus ();

   mult_fu #(.ROB_ID_W(ROB_ID_W), .PREG_W(PREG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Presents an op for one cycle and returns just after its accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] rob, input logic [5:0] pd);
      @(posedge clk);
      #1;
      bus.mul_op          = op;
      bus.rs1_v           = a;
      bus.rs2_v           = b;
      bus.issue_rob_id    = rob;
      bus.issue_pd        = pd;
      bus.start_calculate = 1'b1;
      @(negedge clk);
      chk("issue_ready", {63'd0, bus.mult_status}, 64'd1);
      @(posedge clk);
      #1;
      bus.start_calculate = 1'b0;
   endtask

   // Counts cycles from the accept cycle until write_from_fu is seen; stops at a bound.
   task automatic wait_result(output int lat, output logic busy_st);
      lat     = 1;
      busy_st = 1'bx;
      while (lat < 100) begin
         @(negedge clk);
         if (lat == 10) busy_st = bus.mult_status;
         if (bus.write_from_fu) break;
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic kill_seq(input logic use_rst, input logic in_done);
      int   lat;
      logic bs;
      int   pulses;
      bus.cdb_grant = ~in_done;
      issue(2'b00, 32'd9, 32'd9, 8'h55, 6'h2A);
      if (in_done) begin
         wait_result(lat, bs);
         chk("kill_pre_result", {32'd0, bus.cdb_value}, 64'd81);
      end else begin
         repeat (9) @(posedge clk);
      end
      @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else bus.flush = 1'b1;
      bus.cdb_grant = 1'b1;
      @(negedge clk);
      chk(use_rst ? "rst_status_low" : "flush_status_low", {63'd0, bus.mult_status}, 64'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk(use_rst ? "rst_after" : "flush_after",
          {30'd0, bus.write_from_fu, bus.mult_status, bus.cdb_value}, {30'd0, 2'b01, 32'd0});
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.write_from_fu) pulses++;
      end
      chk(use_rst ? "rst_no_pulse" : "flush_no_pulse", 64'(pulses), 64'd0);
   endtask

   initial begin
      vec_t  vecs [8];
      int    lat;
      logic  bs;
      logic [47:0] hold;

      vecs[0] = '{2'b00, 32'd7,        32'd6,        8'h01, 6'h01, 32'h0000002A};
      vecs[1] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h02, 6'h02, 32'hFFFFFFFE};
      vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h03, 6'h03, 32'h00000000};
      vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h04, 6'h04, 32'hFFFFFFFF};
      vecs[4] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 8'hA5, 6'h3F, 32'h80000000};
      vecs[5] = '{2'b01, 32'h80000000, 32'h80000000, 8'h06, 6'h06, 32'h40000000};
      vecs[6] = '{2'b10, 32'h80000000, 32'h00000002, 8'h07, 6'h07, 32'hFFFFFFFF};
      vecs[7] = '{2'b01, 32'h12345678, 32'h00000010, 8'hFF, 6'h00, 32'h00000001};

      bus.flush           = 1'b0;
      bus.start_calculate = 1'b0;
      bus.mul_op          = 2'b00;
      bus.rs1_v           = 32'd0;
      bus.rs2_v           = 32'd0;
      bus.issue_rob_id    = '0;
      bus.issue_pd        = '0;
      bus.cdb_grant       = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("status_in_reset", {63'd0, bus.mult_status}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_state",
          {22'd0, bus.write_from_fu, bus.mult_status, bus.cdb_rob_id, bus.cdb_pd, bus.cdb_value},
          {22'd0, 1'b0, 1'b1, 8'd0, 6'd0, 32'd0});

      bus.cdb_grant = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rob, vecs[i].pd);
         wait_result(lat, bs);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
         chk($sformatf("v%0d_value", i), {32'd0, bus.cdb_value}, {32'd0, vecs[i].exp});
         chk($sformatf("v%0d_tag", i), {50'd0, bus.cdb_rob_id, bus.cdb_pd}, {50'd0, vecs[i].rob, vecs[i].pd});
         chk($sformatf("v%0d_busy_status", i), {63'd0, bs}, 64'd0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_retire", i), {62'd0, bus.write_from_fu, bus.mult_status}, 64'b01);
      end

      // Back-pressure, with stray starts while busy and while held that must be ignored.
      bus.cdb_grant = 1'b0;
      issue(2'b00, 32'h1234, 32'h10, 8'h33, 6'h11);
      repeat (4) @(posedge clk);
      #1;
      bus.mul_op = 2'b11; bus.rs1_v = 32'hFFFFFFFF; bus.rs2_v = 32'hFFFFFFFF;
      bus.issue_rob_id = 8'h44; bus.issue_pd = 6'h22; bus.start_calculate = 1'b1;
      @(posedge clk);
      #1;
      bus.start_calculate = 1'b0;
      wait_result(lat, bs);
      hold = {1'b1, 1'b0, 8'h33, 6'h11, 32'h00012340};
      chk("bp_first", {16'd0, bus.write_from_fu, bus.mult_status, bus.cdb_rob_id, bus.cdb_pd, bus.cdb_value},
          {16'd0, hold});
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         bus.start_calculate = (c == 4);
         @(negedge clk);
         chk($sformatf("bp_hold%0d", c),
             {16'd0, bus.write_from_fu, bus.mult_status, bus.cdb_rob_id, bus.cdb_pd, bus.cdb_value},
             {16'd0, hold});
      end
      @(posedge clk);
      #1;
      bus.start_calculate = 1'b0;
      bus.cdb_grant       = 1'b1;
      @(negedge clk);
      chk("bp_grant_status", {62'd0, bus.write_from_fu, bus.mult_status}, 64'b11);
      @(posedge clk);
      @(negedge clk);
      chk("bp_handoff", {62'd0, bus.write_from_fu, bus.mult_status}, 64'b01);

      // Back-to-back: retire and accept on the same grant edge.
      bus.cdb_grant = 1'b0;
      issue(2'b00, 32'd2, 32'd2, 8'h21, 6'h05);
      wait_result(lat, bs);
      chk("b2b_first", {32'd0, bus.cdb_value}, 64'd4);
      @(posedge clk);
      #1;
      bus.cdb_grant = 1'b1;
      bus.mul_op = 2'b00; bus.rs1_v = 32'd3; bus.rs2_v = 32'd5;
      bus.issue_rob_id = 8'h22; bus.issue_pd = 6'h06; bus.start_calculate = 1'b1;
      @(negedge clk);
      chk("b2b_status", {62'd0, bus.write_from_fu, bus.mult_status}, 64'b11);
      @(posedge clk);
      #1;
      bus.start_calculate = 1'b0;
      wait_result(lat, bs);
      chk("b2b_latency", 64'(lat), 64'd34);
      chk("b2b_value", {32'd0, bus.cdb_value}, 64'h0F);
      chk("b2b_tag", {50'd0, bus.cdb_rob_id, bus.cdb_pd}, {50'd0, 8'h22, 6'h06});
      @(posedge clk);

      kill_seq(1'b0, 1'b0);
      kill_seq(1'b0, 1'b1);
      kill_seq(1'b1, 1'b0);
      kill_seq(1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
